hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum consecutive memory-wait cycles before the error state; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port rs1_id, input, 5: rs1 index of the instruction in ID.
REQ-005 SHALL have port rs2_id, input, 5: rs2 index of the instruction in ID.
REQ-006 SHALL have ports rs1_used_id and rs2_used_id, input, 1 each: the ID instruction reads that operand.
REQ-007 SHALL have port rd_ex, input, 5: destination index of the instruction in EX.
REQ-008 SHALL have ports read_mem_ex and write_reg_ex, input, 1 each: the EX instruction is a load and writes the register file.
REQ-009 SHALL have port branch_taken_ex, input, 1: the EX branch or jump resolved taken.
REQ-010 SHALL have ports mem_req_mem and mem_ready_mem, input, 1 each: the MEM-stage access is active and the data memory has completed it this cycle.
REQ-011 SHALL have ports stall_pc, stall_if_id, stall_id_ex and stall_ex_mem, output, 1 each: hold the corresponding pipeline register.
REQ-012 SHALL have ports flush_if_id and flush_id_ex, output, 1 each: load a bubble (all zeros) into the register.
REQ-013 SHALL have port mem_timeout, output, 1: sticky error flag.
REQ-014 SHALL have port hz_state, output, 2: current state, RUN=0, MEM_WAIT=1, ERR=2.
REQ-015 SHALL have port stall_cycles, output, 16: count of stalled cycles.

Function
REQ-016 SHALL define mem_stall = mem_req_mem & ~mem_ready_mem.
REQ-017 SHALL define load_use = read_mem_ex & write_reg_ex & (rd_ex != 0) & ((rs1_used_id & rs1_id == rd_ex) | (rs2_used_id & rs2_id == rd_ex)).
REQ-018 SHALL implement states RUN, MEM_WAIT and ERR; the stall and flush outputs are combinational from the state and the inputs, in the same cycle.
REQ-019 In RUN with mem_stall, SHALL assert all four stall_* outputs and go to MEM_WAIT with the wait counter set to 1.
REQ-020 In MEM_WAIT with mem_stall, SHALL keep all four stalls asserted and increment the wait counter.
REQ-021 In MEM_WAIT with ~mem_stall, SHALL deassert all stalls in that same cycle and return to RUN.
REQ-022 In MEM_WAIT, when the wait counter equals TIMEOUT and mem_stall is still 1, SHALL enter ERR on the next edge.
REQ-023 In ERR, SHALL assert all four stalls and mem_timeout continuously; ERR is left only by reset.
REQ-024 In RUN with no mem_stall and branch_taken_ex=1, SHALL assert flush_if_id and flush_id_ex for that cycle with no stall; load_use is ignored in that cycle.
REQ-025 In RUN with no mem_stall, no branch and load_use=1, SHALL assert stall_pc, stall_if_id and flush_id_ex for exactly that cycle, with stall_id_ex=0 and stall_ex_mem=0.
REQ-026 SHALL apply priority ERR > mem_stall > branch_taken_ex > load_use.
REQ-027 SHALL never assert any flush output while any stall_* output is asserted.
REQ-028 SHALL treat rd_ex=0 as never a hazard.
REQ-029 SHALL increment stall_cycles by 1 on every edge where stall_pc=1, saturating at 0xFFFF with no wrap.
REQ-030 SHALL make hz_state equal the registered state.

Reset
REQ-031 While rst_n=0, and immediately on its assertion even mid-wait, SHALL force state RUN, wait counter 0, stall_cycles 0 and mem_timeout 0.
REQ-032 While rst_n=0, SHALL drive every stall_* and flush_* output to 0 regardless of inputs.
REQ-033 SHALL release reset only on a clk edge where rst_n is sampled 1; the first evaluation is in RUN.

Verification
REQ-034 Load-use: rd_ex=5, read_mem_ex=1, write_reg_ex=1, rs1_id=5, rs1_used_id=1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle, stall_cycles=1.
REQ-035 Same stimulus with rd_ex=0, or with rs1_used_id=0 -> all hazard outputs 0.
REQ-036 Branch together with load_use -> flush_if_id=flush_id_ex=1, stall_pc=0, stall_cycles unchanged.
REQ-037 mem_req_mem=1 with mem_ready_mem low for 3 cycles, then high -> stalls high for 3 cycles, hz_state sequence 0,1,1,1 then 0, stall_cycles=3.
REQ-038 TIMEOUT=4 with mem_ready_mem held 0 -> ERR after 5 stalled cycles, mem_timeout=1 and hz_state=2 stay until rst_n pulses low, after which all outputs are 0.
REQ-039 Drive 70000 stalled cycles -> stall_cycles holds at 0xFFFF; reset asserted mid-MEM_WAIT -> outputs drop to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard unit signal bundle
interface hazard_ctrl_if;
   logic [4:0]  rs1_id;
   logic [4:0]  rs2_id;
   logic        rs1_used_id;
   logic        rs2_used_id;
   logic [4:0]  rd_ex;
   logic        read_mem_ex;
   logic        write_reg_ex;
   logic        branch_taken_ex;
   logic        mem_req_mem;
   logic        mem_ready_mem;
   logic        stall_pc;
   logic        stall_if_id;
   logic        stall_id_ex;
   logic        stall_ex_mem;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        mem_timeout;
   logic [1:0]  hz_state;
   logic [15:0] stall_cycles;

   // Pipeline side: reports stage contents, obeys stall/flush controls
   modport master (
      output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, read_mem_ex,
             write_reg_ex, branch_taken_ex, mem_req_mem, mem_ready_mem,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
             flush_id_ex, mem_timeout, hz_state, stall_cycles
   );

   // Hazard unit side
   modport slave (
      input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, read_mem_ex,
             write_reg_ex, branch_taken_ex, mem_req_mem, mem_ready_mem,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
             flush_id_ex, mem_timeout, hz_state, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: load-use, branch flush, memory wait with timeout
module hazard_ctrl #(
   parameter int TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] wait_cnt;
   logic [15:0] wait_nxt;
   logic [15:0] stall_cnt;

   logic mem_stall;
   logic load_use;
   logic stall_all;
   logic stall_front;
   logic flush_front;
   logic flush_back;
   logic stall_pc_int;

   assign mem_stall = hz.mem_req_mem & ~hz.mem_ready_mem;

   // A load into x0 never creates a dependency, whatever the ID operands are
   assign load_use = hz.read_mem_ex & hz.write_reg_ex & (hz.rd_ex != 5'd0) &
                     ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) |
                      (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));

   // Next state, wait counter and raw stall/flush decisions (priority ERR > mem > branch > load-use)
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      stall_all   = 1'b0;
      stall_front = 1'b0;
      flush_front = 1'b0;
      flush_back  = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) begin
               stall_all = 1'b1;
               state_nxt = MEM_WAIT;
               wait_nxt  = 16'd1;
            end else if (hz.branch_taken_ex) begin
               flush_front = 1'b1;
               flush_back  = 1'b1;
            end else if (load_use) begin
               stall_front = 1'b1;
               flush_back  = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               stall_all = 1'b1;
               if (wait_cnt == WAIT_LIMIT) begin
                  state_nxt = ERR;
               end else begin
                  wait_nxt = wait_cnt + 16'd1;
               end
            end else begin
               state_nxt = RUN;
               wait_nxt  = 16'd0;
            end
         end
         ERR: begin
            stall_all = 1'b1;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = 16'd0;
         end
      endcase
   end

   // Outputs are gated by rst_n so they drop the instant reset is asserted
   assign stall_pc_int    = rst_n & (stall_all | stall_front);
   assign hz.stall_pc     = stall_pc_int;
   assign hz.stall_if_id  = rst_n & (stall_all | stall_front);
   assign hz.stall_id_ex  = rst_n & stall_all;
   assign hz.stall_ex_mem = rst_n & stall_all;
   assign hz.flush_if_id  = rst_n & flush_front;
   assign hz.flush_id_ex  = rst_n & flush_back;
   assign hz.mem_timeout  = (state == ERR);
   assign hz.hz_state     = state;
   assign hz.stall_cycles = stall_cnt;

   // State and memory-wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 16'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Saturating count of cycles in which the PC was held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
      end else if (stall_pc_int && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model: mode 0 run, 1 waiting on memory, 2 dead; wait length; stall count
   int m_state = 0;
   int m_wait  = 0;
   int m_cnt   = 0;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] r1, r2, rd;
      logic       u1, u2, rm, wr, br, mq, mr;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                               input logic u2, input logic [4:0] rd, input logic rm,
                               input logic wr, input logic br, input logic mq, input logic mr,
                               input logic [8:0] exp);
      vec_t v;
      v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2; v.rd = rd; v.rm = rm; v.wr = wr;
      v.br = br; v.mq = mq; v.mr = mr; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, mem_timeout, hz_state}
   function automatic logic [8:0] dut_out();
      return {hif.stall_pc, hif.stall_if_id, hif.stall_id_ex, hif.stall_ex_mem,
              hif.flush_if_id, hif.flush_id_ex, hif.mem_timeout, hif.hz_state};
   endfunction

   function automatic logic [8:0] m_out();
      bit mem_busy, dep, r1_dep, r2_dep;
      logic [8:0] r;
      mem_busy = hif.mem_req_mem && !hif.mem_ready_mem;
      r1_dep = hif.rs1_used_id && (hif.rs1_id == hif.rd_ex);
      r2_dep = hif.rs2_used_id && (hif.rs2_id == hif.rd_ex);
      dep = hif.read_mem_ex && hif.write_reg_ex && (hif.rd_ex != 0) && (r1_dep || r2_dep);
      r = 9'd0;
      if (!rst_n) return 9'd0;
      if (m_state == 2)                    r = 9'b1111_00_1_00;
      else if (mem_busy)                   r = 9'b1111_00_0_00;
      else if (m_state == 0 && hif.branch_taken_ex) r = 9'b0000_11_0_00;
      else if (m_state == 0 && dep)        r = 9'b1100_01_0_00;
      r[1:0] = 2'(m_state);
      return r;
   endfunction

   task automatic model_edge();
      logic [8:0] o;
      bit mem_busy;
      o = m_out();
      mem_busy = hif.mem_req_mem && !hif.mem_ready_mem;
      if (!rst_n) begin
         m_state = 0; m_wait = 0; m_cnt = 0;
      end else begin
         if (o[8]) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
         if (m_state == 0 && mem_busy) begin
            m_state = 1; m_wait = 1;
         end else if (m_state == 1) begin
            if (!mem_busy) begin
               m_state = 0; m_wait = 0;
            end else if (m_wait >= TO) begin
               m_state = 2;
            end else begin
               m_wait++;
            end
         end
      end
   endtask

   task automatic clear_in();
      hif.rs1_id = 0; hif.rs2_id = 0; hif.rs1_used_id = 0; hif.rs2_used_id = 0;
      hif.rd_ex = 0; hif.read_mem_ex = 0; hif.write_reg_ex = 0; hif.branch_taken_ex = 0;
      hif.mem_req_mem = 0; hif.mem_ready_mem = 0;
   endtask

   // inputs are already driven ~1 after an edge; check mid-cycle, then advance
   task automatic cyc(input string nm);
      #3;
      chk({nm, "_out"}, 32'(dut_out()), 32'(m_out()));
      chk({nm, "_cnt"}, 32'(hif.stall_cycles), 32'(m_cnt));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_state = 0; m_wait = 0; m_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear_in();
      #1;
      chk("reset_outputs", 32'(dut_out()), 32'd0);
      do_reset();
      chk("reset_cnt", 32'(hif.stall_cycles), 32'd0);

      // single-cycle decisions from RUN
      tbl[0]  = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 9'b0000_00_0_00);
      tbl[1]  = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 9'b1100_01_0_00);
      tbl[2]  = mk(5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, 9'b0000_00_0_00);
      tbl[3]  = mk(5'd5, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 9'b0000_00_0_00);
      tbl[4]  = mk(5'd1, 1, 5'd9, 1, 5'd9, 1, 1, 0, 0, 0, 9'b1100_01_0_00);
      tbl[5]  = mk(5'd1, 1, 5'd9, 0, 5'd9, 1, 1, 0, 0, 0, 9'b0000_00_0_00);
      tbl[6]  = mk(5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0, 9'b0000_00_0_00);
      tbl[7]  = mk(5'd7, 1, 5'd0, 0, 5'd7, 0, 1, 0, 0, 0, 9'b0000_00_0_00);
      tbl[8]  = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, 0, 9'b0000_11_0_00);
      tbl[9]  = mk(5'd0, 0, 5'd0, 0, 5'd3, 0, 0, 1, 0, 0, 9'b0000_11_0_00);
      tbl[10] = mk(5'd31, 0, 5'd31, 1, 5'd31, 1, 1, 0, 1, 1, 9'b1100_01_0_00);
      tbl[11] = mk(5'd4, 1, 5'd4, 1, 5'd4, 1, 1, 1, 1, 1, 9'b0000_11_0_00);

      for (int i = 0; i < 12; i++) begin
         hif.rs1_id = tbl[i].r1; hif.rs1_used_id = tbl[i].u1;
         hif.rs2_id = tbl[i].r2; hif.rs2_used_id = tbl[i].u2;
         hif.rd_ex = tbl[i].rd; hif.read_mem_ex = tbl[i].rm; hif.write_reg_ex = tbl[i].wr;
         hif.branch_taken_ex = tbl[i].br; hif.mem_req_mem = tbl[i].mq; hif.mem_ready_mem = tbl[i].mr;
         #3;
         chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
         @(posedge clk);
         model_edge();
         #1;
      end
      chk("vec_cnt", 32'(hif.stall_cycles), 32'd3);

      // lone load-use from a fresh reset counts exactly one stall
      clear_in();
      do_reset();
      hif.rd_ex = 5; hif.read_mem_ex = 1; hif.write_reg_ex = 1; hif.rs1_id = 5; hif.rs1_used_id = 1;
      cyc("lu");
      clear_in();
      #3;
      chk("lu_once_out", 32'(dut_out()), 32'd0);
      chk("lu_once_cnt", 32'(hif.stall_cycles), 32'd1);
      @(posedge clk); model_edge(); #1;

      // three memory wait cycles then ready
      do_reset();
      hif.mem_req_mem = 1; hif.mem_ready_mem = 0;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk($sformatf("mw_state%0d", i), 32'(hif.hz_state), (i == 0) ? 32'd0 : 32'd1);
         chk($sformatf("mw_stall%0d", i), 32'(dut_out() >> 5), 32'hF);
         @(posedge clk); model_edge(); #1;
      end
      hif.mem_ready_mem = 1;
      #3;
      chk("mw_release_state", 32'(hif.hz_state), 32'd1);
      chk("mw_release_out", 32'(dut_out()), 32'b0000_00_0_01);
      @(posedge clk); model_edge(); #1;
      chk("mw_back_state", 32'(hif.hz_state), 32'd0);
      chk("mw_cnt", 32'(hif.stall_cycles), 32'd3);

      // timeout into ERR, sticky until reset
      clear_in();
      do_reset();
      hif.mem_req_mem = 1; hif.mem_ready_mem = 0;
      for (int i = 0; i < 5; i++) cyc("to");
      chk("to_state", 32'(hif.hz_state), 32'd2);
      chk("to_flag", 32'(hif.mem_timeout), 32'd1);
      hif.mem_ready_mem = 1;
      for (int i = 0; i < 4; i++) cyc("err_hold");
      chk("err_sticky", 32'(dut_out()), 32'b1111_00_1_10);
      rst_n = 0;
      #1;
      chk("err_rst_out", 32'(dut_out()), 32'd0);
      chk("err_rst_cnt", 32'(hif.stall_cycles), 32'd0);
      clear_in();
      do_reset();

      // randomized traffic against the model, with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         hif.rs1_id = 5'($urandom_range(0, 3)); hif.rs2_id = 5'($urandom_range(0, 3));
         hif.rd_ex = 5'($urandom_range(0, 3));
         hif.rs1_used_id = 1'($urandom); hif.rs2_used_id = 1'($urandom);
         hif.read_mem_ex = 1'($urandom); hif.write_reg_ex = 1'($urandom);
         hif.branch_taken_ex = ($urandom_range(0, 3) == 0);
         hif.mem_req_mem = ($urandom_range(0, 2) == 0);
         hif.mem_ready_mem = ($urandom_range(0, 2) != 0);
         rst_n = ($urandom_range(0, 60) != 0);
         if (!rst_n) begin m_state = 0; m_wait = 0; m_cnt = 0; end
         cyc("rnd");
      end
      rst_n = 1;

      // counter saturation, then asynchronous reset mid-wait
      clear_in();
      do_reset();
      hif.mem_req_mem = 1; hif.mem_ready_mem = 0;
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk); model_edge();
      end
      #1;
      chk("sat_cnt", 32'(hif.stall_cycles), 32'hFFFF);
      chk("sat_model", 32'(hif.stall_cycles), 32'(m_cnt));
      clear_in();
      do_reset();
      hif.mem_req_mem = 1; hif.mem_ready_mem = 0;
      cyc("mid");
      cyc("mid");
      chk("mid_state", 32'(hif.hz_state), 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_out", 32'(dut_out()), 32'd0);
      chk("mid_rst_cnt", 32'(hif.stall_cycles), 32'd0);
      m_state = 0; m_wait = 0; m_cnt = 0;
      @(posedge clk); #1;
      chk("held_rst_out", 32'(dut_out()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
